mips_bus_arbiter: RTL
=====================

Name: mips_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the CPU memory bus (address/read/write/writedata/byteenable/readdata/waitrequest).
- Master 0 is the instruction-fetch port and master 1 is the load/store port; the slave is the shared RAM.
- Serialises transfers using round-robin grant, propagates slave wait-states, and aborts transfers that stall past a timeout.

Parameters:
- AW, 32, address width
- DW, 32, data width (byteenable width = DW/8)
- TIMEOUT, 64, maximum consecutive slave waitrequest cycles before abort; minimum 1

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (reset=0 clears all state immediately)
- m0_address  in  AW  master 0 byte address
- m0_read  in  1  master 0 read request
- m0_write  in  1  master 0 write request
- m0_writedata  in  DW  master 0 write data
- m0_byteenable  in  DW/8  master 0 byte lanes
- m0_readdata  out  DW  master 0 read data
- m0_waitrequest  out  1  master 0 stall
- m1_*  same seven signals as m0_*, for master 1
- s_address  out  AW  slave address
- s_read  out  1  slave read strobe
- s_write  out  1  slave write strobe
- s_writedata  out  DW  slave write data
- s_byteenable  out  DW/8  slave byte lanes
- s_readdata  in  DW  slave read data, valid the cycle after an accepted read
- s_waitrequest  in  1  slave stall
- timeout_err  out  1  sticky, a transfer was aborted on timeout
- protocol_err  out  1  sticky, a master asserted read and write together

Behaviour:
- Reset (reset=0, async): state=IDLE, owner=0, last_grant=1 (so m0 wins the first tie), timeout counter=0, both error flags=0, all s_* outputs=0, mN_readdata=0. Masters whose request is asserted during reset see mN_waitrequest=1.
- req_N = mN_read | mN_write. If both are high, the transfer is a write and protocol_err is set on that clock edge.
- mN_waitrequest = req_N & ~(done_N), where done_N is high for exactly one cycle at completion. A master holds all its inputs stable while waitrequest=1.
- IDLE:
  - s_* outputs=0.
  - One requester: grant it.
  - Both requesting: grant the one not equal to last_grant.
  - On grant: owner<=winner, last_grant<=winner, counter<=0, go to ISSUE. Arbitration costs 1 cycle.
- ISSUE:
  - s_* are combinationally muxed from the owner's inputs.
  - If s_waitrequest=1: counter++. If counter reaches TIMEOUT-1 while s_waitrequest is still 1: drop the s_ strobes next cycle, assert done_owner this cycle with readdata=0, set timeout_err, go to IDLE.
  - If s_waitrequest=0 and the transfer is a write: done_owner=1 this cycle, go to IDLE.
  - If s_waitrequest=0 and the transfer is a read: go to RESP.
- RESP:
  - s_read=0.
  - mOwner_readdata = s_readdata (combinational pass) and registered into a hold register.
  - done_owner=1, go to IDLE.
- mN_readdata outside its done cycle shows the last value delivered to that master.
- Minimum latency from request to done: write 2 cycles (IDLE, ISSUE); read 3 cycles (IDLE, ISSUE, RESP).
- A non-owner request is held off with waitrequest=1 for the whole owner transfer. After the owner finishes, the waiting master wins the next arbitration (round-robin), so no master is starved.
- A request dropped while not granted is ignored. Dropping a request while granted is illegal and gives undefined behaviour.
- Reset asserted mid-transfer: s_read/s_write fall asynchronously, the transfer is lost, and no done pulse is produced.
- Error flags clear only on reset.

Test Plan:
- m0 single read of 0xBFC00004, slave waitrequest=0, s_readdata=0x1234ABCD: s_read high 1 cycle; m0_waitrequest low in the 3rd cycle with m0_readdata=0x1234ABCD.
- m1 write 0xBFC00008, writedata=0x00000001, byteenable=0b0011, slave stalls 3 cycles: s_write/s_byteenable held for 4 cycles; m1 done in cycle 5.
- m0 and m1 request in the same cycle, repeatedly for 4 transfers: grants go m0, m1, m0, m1; the waiting master sees waitrequest=1 throughout the other's transfer.
- TIMEOUT=4, slave waitrequest stuck at 1: abort after 4 ISSUE cycles; master done with readdata=0; timeout_err=1 until reset.
- m1_read and m1_write both high: treated as a write, protocol_err=1.
- Assert reset=0 mid-ISSUE: s_read drops the same cycle; after release the state is IDLE and the next tie goes to m0.

Source files
------------

// File: rtl/mips_bus_arbiter.sv
// Two-master, one-slave round-robin bus arbiter for the CPU memory bus.
// Master 0 is instruction fetch, master 1 is load/store; stalled transfers are aborted after TIMEOUT waits.
module mips_bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   m0_address,
  input  logic            m0_read,
  input  logic            m0_write,
  input  logic [DW-1:0]   m0_writedata,
  input  logic [DW/8-1:0] m0_byteenable,
  output logic [DW-1:0]   m0_readdata,
  output logic            m0_waitrequest,
  input  logic [AW-1:0]   m1_address,
  input  logic            m1_read,
  input  logic            m1_write,
  input  logic [DW-1:0]   m1_writedata,
  input  logic [DW/8-1:0] m1_byteenable,
  output logic [DW-1:0]   m1_readdata,
  output logic            m1_waitrequest,
  output logic [AW-1:0]   s_address,
  output logic            s_read,
  output logic            s_write,
  output logic [DW-1:0]   s_writedata,
  output logic [DW/8-1:0] s_byteenable,
  input  logic [DW-1:0]   s_readdata,
  input  logic            s_waitrequest,
  output logic            timeout_err,
  output logic            protocol_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          terr_q, terr_d;
  logic          perr_q, perr_d;
  logic [DW-1:0] rd0_q, rd0_d;
  logic [DW-1:0] rd1_q, rd1_d;

  logic          req0, req1, winner, done, abort, deliver;
  logic          own_rd, own_wr;
  logic [DW-1:0] rd_val;

  assign req0   = m0_read | m0_write;
  assign req1   = m1_read | m1_write;
  assign own_rd = owner_q ? m1_read : m0_read;
  assign own_wr = owner_q ? m1_write : m0_write;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    terr_d       = terr_q;
    perr_d       = perr_q | (m0_read & m0_write) | (m1_read & m1_write);
    winner       = 1'b0;
    done         = 1'b0;
    abort        = 1'b0;
    s_address    = '0;
    s_read       = 1'b0;
    s_write      = 1'b0;
    s_writedata  = '0;
    s_byteenable = '0;
    unique case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          // On a tie the master that did not win last time goes first.
          winner  = (req0 & req1) ? ~last_q : req1;
          owner_d = winner;
          last_d  = winner;
          cnt_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        s_address    = owner_q ? m1_address : m0_address;
        s_write      = own_wr;
        s_read       = own_rd & ~own_wr;
        s_writedata  = owner_q ? m1_writedata : m0_writedata;
        s_byteenable = owner_q ? m1_byteenable : m0_byteenable;
        if (s_waitrequest) begin
          if (cnt_q == CNT_LAST) begin
            done    = 1'b1;
            abort   = 1'b1;
            terr_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (own_wr) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A read completion or an abort delivers data; an abort delivers zero.
  assign deliver = abort | (state_q == S_RESP);
  assign rd_val  = abort ? '0 : s_readdata;
  assign rd0_d   = (deliver & ~owner_q) ? rd_val : rd0_q;
  assign rd1_d   = (deliver &  owner_q) ? rd_val : rd1_q;

  assign m0_readdata    = rd0_d;
  assign m1_readdata    = rd1_d;
  assign m0_waitrequest = req0 & ~(done & ~owner_q);
  assign m1_waitrequest = req1 & ~(done & owner_q);
  assign timeout_err    = terr_q;
  assign protocol_err   = perr_q;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
      perr_q  <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
      perr_q  <= perr_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

endmodule
